mem_arbiter: RTL and testbench

- Time-slot sequencer that shares the single external SRAM bus between the 6502 CPU and the SPI bridge.
- Each frame is two fixed slots: a CPU slot, then an SPI slot. The block advances the CPU by one clock-enable strobe per frame.
- It services at most one SPI bridge transfer per frame via the valid/done handshake, and returns read data to the bridge.
- Sits between the CPU/SPI bridge and the SRAM pins.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_slot_timer.sv | 45 ++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the SRAM time-slot arbiter: slot identifiers, debug state codes, write-strobe window.
// Pure declarations; no latency and no backpressure.
package mem_arbiter_pkg;

  localparam int CNT_W = 5;

  typedef enum logic {
    SLOT_CPU = 1'b0,
    SLOT_SPI = 1'b1
  } slot_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CPU      = 2'd1;
  localparam logic [1:0] ST_SPI      = 2'd2;
  localparam logic [1:0] ST_SPI_IDLE = 2'd3;

  // Write strobe excludes the first and last cycle of a slot for address setup and hold.
  function automatic logic in_we_window(input logic [CNT_W-1:0] cnt, input int slot_cycles);
    return (int'(cnt) >= 1) && (int'(cnt) <= slot_cycles - 2);
  endfunction

endpackage

// File: rtl/mem_arbiter_slot_timer.sv
// Slot cycle counter with CPU/SPI slot toggle; flags describe the cycle about to start.
// Free running, no backpressure; flags are combinational from the current count.
module slot_timer
  import mem_arbiter_pkg::*;
#(
  parameter int SLOT_CYCLES = 8
) (
  input  logic  clk,
  input  logic  reset,
  output slot_t slot,
  output logic  last,
  output slot_t nxt_slot,
  output logic  nxt_first,
  output logic  nxt_last,
  output logic  nxt_we
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    last     = (cnt == LAST_CNT);
    cnt_nxt  = last ? '0 : cnt + 1'b1;
    nxt_slot = slot;
    if (last) begin
      nxt_slot = (slot == SLOT_CPU) ? SLOT_SPI : SLOT_CPU;
    end
    nxt_first = (cnt_nxt == '0);
    nxt_last  = (cnt_nxt == LAST_CNT);
    nxt_we    = in_we_window(cnt_nxt, SLOT_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      slot <= SLOT_CPU;
    end else begin
      cnt  <= cnt_nxt;
      slot <= nxt_slot;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the SRAM bus between CPU and SPI bridge in fixed CPU/SPI slots; all outputs registered.
// CPU is never stalled; one bridge transfer per valid assertion, done pulses on the next CPU slot's first cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int SLOT_CYCLES = 8,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic                  clk_sys_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [7:0]            cpu_data_i,
  input  logic                  cpu_rw_ni,
  output logic                  cpu_clk_en_o,
  input  logic [ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [7:0]            spi_data_i,
  input  logic                  spi_rw_ni,
  input  logic                  spi_valid_i,
  output logic                  spi_done_o,
  output logic [7:0]            spi_data_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_data_o,
  input  logic [7:0]            ram_data_i,
  output logic                  ram_oe_no,
  output logic                  ram_we_no,
  output logic [1:0]            state_o
);

  slot_t slot;
  slot_t nxt_slot;
  logic  last;
  logic  nxt_first;
  logic  nxt_last;
  logic  nxt_we;

  slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_slot_timer (
    .clk       (clk_sys_i),
    .reset     (reset_i),
    .slot      (slot),
    .last      (last),
    .nxt_slot  (nxt_slot),
    .nxt_first (nxt_first),
    .nxt_last  (nxt_last),
    .nxt_we    (nxt_we)
  );

  logic                  grant, grant_nxt;
  logic                  served, served_nxt;
  logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nxt;
  logic [7:0]            lat_data, lat_data_nxt;
  logic                  lat_rw, lat_rw_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [7:0]            wdat_nxt;
  logic [7:0]            rdat_nxt;
  logic                  oe_nxt;
  logic                  we_nxt;
  logic                  clk_en_nxt;
  logic                  done_nxt;
  logic [1:0]            state_nxt;

  // Outputs are computed for the cycle about to start, so strobes line up with the slot count.
  always_comb begin
    grant_nxt    = grant;
    lat_addr_nxt = lat_addr;
    lat_data_nxt = lat_data;
    lat_rw_nxt   = lat_rw;
    addr_nxt     = ram_addr_o;
    wdat_nxt     = ram_data_o;
    oe_nxt       = 1'b1;
    we_nxt       = 1'b1;
    clk_en_nxt   = 1'b0;
    state_nxt    = ST_SPI_IDLE;

    done_nxt   = (slot == SLOT_SPI) && last && grant;
    rdat_nxt   = (done_nxt && lat_rw) ? ram_data_i : spi_data_o;
    served_nxt = spi_valid_i && (served || done_nxt);

    if (nxt_slot == SLOT_CPU) begin
      grant_nxt  = 1'b0;
      state_nxt  = ST_CPU;
      addr_nxt   = cpu_addr_i;
      wdat_nxt   = cpu_data_i;
      oe_nxt     = ~cpu_rw_ni;
      we_nxt     = ~(~cpu_rw_ni && nxt_we);
      clk_en_nxt = nxt_last;
    end else begin
      if (nxt_first) begin
        grant_nxt = spi_valid_i && !served;
        if (grant_nxt) begin
          lat_addr_nxt = spi_addr_i;
          lat_data_nxt = spi_data_i;
          lat_rw_nxt   = spi_rw_ni;
        end
      end
      if (grant_nxt) begin
        state_nxt = ST_SPI;
        addr_nxt  = lat_addr_nxt;
        wdat_nxt  = lat_data_nxt;
        oe_nxt    = ~lat_rw_nxt;
        we_nxt    = ~(~lat_rw_nxt && nxt_we);
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      grant        <= 1'b0;
      served       <= 1'b0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_rw       <= 1'b1;
      cpu_clk_en_o <= 1'b0;
      spi_done_o   <= 1'b0;
      spi_data_o   <= '0;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
      ram_oe_no    <= 1'b1;
      ram_we_no    <= 1'b1;
      state_o      <= ST_IDLE;
    end else begin
      grant        <= grant_nxt;
      served       <= served_nxt;
      lat_addr     <= lat_addr_nxt;
      lat_data     <= lat_data_nxt;
      lat_rw       <= lat_rw_nxt;
      cpu_clk_en_o <= clk_en_nxt;
      spi_done_o   <= done_nxt;
      spi_data_o   <= rdat_nxt;
      ram_addr_o   <= addr_nxt;
      ram_data_o   <= wdat_nxt;
      ram_oe_no    <= oe_nxt;
      ram_we_no    <= we_nxt;
      state_o      <= state_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed frame table, hand-written SPI sequences, then random traffic against a frame-position model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int S  = 8;
  localparam int F  = 2 * S;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [AW-1:0] cpu_addr_i, spi_addr_i;
  logic [7:0]    cpu_data_i, spi_data_i, ram_data_i;
  logic          cpu_rw_ni, spi_rw_ni, spi_valid_i;
  logic          cpu_clk_en_o, spi_done_o, ram_oe_no, ram_we_no;
  logic [7:0]    spi_data_o, ram_data_o;
  logic [AW-1:0] ram_addr_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  mem_arbiter #(.SLOT_CYCLES(S), .ADDR_WIDTH(AW)) dut (
    .clk_sys_i(clk), .reset_i(reset_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_rw_ni(cpu_rw_ni), .cpu_clk_en_o(cpu_clk_en_o),
    .spi_addr_i(spi_addr_i), .spi_data_i(spi_data_i), .spi_rw_ni(spi_rw_ni), .spi_valid_i(spi_valid_i),
    .spi_done_o(spi_done_o), .spi_data_o(spi_data_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .ram_oe_no(ram_oe_no), .ram_we_no(ram_we_no), .state_o(state_o)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;
  int we_lows, oe_lows, en_seen, done_seen;

  // Reference: position in the frame is just n mod 2S since the reset release.
  logic          m_grant, m_served, m_rw;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  logic          e_en, e_done, e_oe, e_we;
  logic [7:0]    e_rdat, e_wdat;
  logic [AW-1:0] e_addr;
  logic [1:0]    e_state;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_edge();
    int  cnt;
    bit  spi_slot, done_now, served_old;
    if (reset_i) begin
      n = 0; m_grant = 0; m_served = 0; m_rw = 1; m_addr = '0; m_data = '0;
      e_en = 0; e_done = 0; e_oe = 1; e_we = 1; e_rdat = '0; e_wdat = '0; e_addr = '0; e_state = ST_IDLE;
      return;
    end
    done_now   = ((n / S) % 2 == 1) && (n % S == S - 1) && m_grant;
    served_old = m_served;
    if (done_now && m_rw) e_rdat = ram_data_i;
    e_done   = done_now;
    m_served = spi_valid_i && (m_served || done_now);
    n++;
    cnt      = n % S;
    spi_slot = ((n / S) % 2 == 1);
    e_en = 0; e_oe = 1; e_we = 1;
    if (!spi_slot) begin
      m_grant = 0;
      e_state = ST_CPU; e_addr = cpu_addr_i; e_wdat = cpu_data_i;
      e_oe = !cpu_rw_ni;
      e_we = !(!cpu_rw_ni && cnt >= 1 && cnt <= S - 2);
      e_en = (cnt == S - 1);
    end else begin
      if (cnt == 0) begin
        m_grant = spi_valid_i && !served_old;
        if (m_grant) begin m_addr = spi_addr_i; m_data = spi_data_i; m_rw = spi_rw_ni; end
      end
      if (m_grant) begin
        e_state = ST_SPI; e_addr = m_addr; e_wdat = m_data;
        e_oe = !m_rw;
        e_we = !(!m_rw && cnt >= 1 && cnt <= S - 2);
      end else begin
        e_state = ST_SPI_IDLE;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("clk_en", cpu_clk_en_o, e_en);
    chk("done", spi_done_o, e_done);
    chk("spi_data", spi_data_o, e_rdat);
    chk("ram_addr", ram_addr_o, e_addr);
    chk("ram_wdata", ram_data_o, e_wdat);
    chk("oe_n", ram_oe_no, e_oe);
    chk("we_n", ram_we_no, e_we);
    chk("state", state_o, e_state);
    if (!ram_we_no) we_lows++;
    if (!ram_oe_no) oe_lows++;
    if (cpu_clk_en_o) en_seen++;
    if (spi_done_o) done_seen++;
  endtask

  task automatic wait_pos(input int p);
    int g = 0;
    while ((n % F) != p && g < 2 * F) begin
      step();
      g++;
    end
    chk("align", n % F, p);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          rw;
    int            exp_we;
    int            exp_oe;
    int            exp_en;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int g;
    tbl[0] = '{17'h08000, 8'h55, 1'b0, S - 2, 0, 1};
    tbl[1] = '{17'h1FFFF, 8'hAA, 1'b1, 0,     S, 1};
    tbl[2] = '{17'h00000, 8'h00, 1'b0, S - 2, 0, 1};
    tbl[3] = '{17'h12345, 8'hC3, 1'b1, 0,     S, 1};

    reset_i = 1; cpu_addr_i = '0; cpu_data_i = '0; cpu_rw_ni = 1;
    spi_addr_i = '0; spi_data_i = '0; spi_rw_ni = 1; spi_valid_i = 0; ram_data_i = '0;
    repeat (3) step();
    chk("rst_oe", ram_oe_no, 1);
    chk("rst_we", ram_we_no, 1);
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_addr", ram_addr_o, 0);
    reset_i = 0;

    // One frame per row: strobe counts over the whole frame, SPI idle.
    for (int i = 0; i < 4; i++) begin
      wait_pos(F - 1);
      cpu_addr_i = tbl[i].addr; cpu_data_i = tbl[i].data; cpu_rw_ni = tbl[i].rw;
      we_lows = 0; oe_lows = 0; en_seen = 0;
      step();
      chk("tbl_addr", ram_addr_o, tbl[i].addr);
      chk("tbl_wdata", ram_data_o, tbl[i].data);
      repeat (F - 1) step();
      chk("tbl_we_lows", we_lows, tbl[i].exp_we);
      chk("tbl_oe_lows", oe_lows, tbl[i].exp_oe);
      chk("tbl_en_count", en_seen, tbl[i].exp_en);
    end

    // SPI read raised during the CPU slot.
    cpu_rw_ni = 1; spi_addr_i = 17'h01F00; spi_rw_ni = 1; ram_data_i = 8'hA5;
    wait_pos(2);
    spi_valid_i = 1;
    wait_pos(S);
    chk("rd_state", state_o, ST_SPI);
    chk("rd_addr", ram_addr_o, 17'h01F00);
    g = 0;
    while (!spi_done_o && g < 4 * F) begin step(); g++; end
    chk("rd_done_pos", n % F, 0);
    chk("rd_data", spi_data_o, 8'hA5);
    ram_data_i = 8'h11;
    step();
    chk("rd_done_width", spi_done_o, 0);
    done_seen = 0;
    repeat (5 * F) step();
    chk("hold_no_redone", done_seen, 0);
    chk("hold_data_kept", spi_data_o, 8'hA5);
    spi_valid_i = 0;
    step();
    spi_valid_i = 1;
    done_seen = 0;
    repeat (3 * F) step();
    chk("retrigger_once", done_seen, 1);
    chk("retrigger_data", spi_data_o, 8'h11);

    // SPI write with valid rising mid-slot: serviced one frame later.
    spi_valid_i = 0;
    step();
    spi_addr_i = 17'h10000; spi_data_i = 8'h3C; spi_rw_ni = 0;
    wait_pos(S + 3);
    spi_valid_i = 1;
    wait_pos(F - 1);
    chk("late_no_grant", state_o, ST_SPI_IDLE);
    we_lows = 0;
    wait_pos(S);
    chk("late_state", state_o, ST_SPI);
    chk("late_addr", ram_addr_o, 17'h10000);
    chk("late_wdata", ram_data_o, 8'h3C);
    wait_pos(F - 1);
    chk("late_we_lows", we_lows, S - 2);
    step();
    chk("late_done", spi_done_o, 1);
    spi_valid_i = 0;

    // Reset in the middle of a granted write.
    step();
    spi_valid_i = 1;
    wait_pos(S + 4);
    chk("pre_rst_we", ram_we_no, 0);
    reset_i = 1; spi_valid_i = 0;
    step();
    chk("rst_we_release", ram_we_no, 1);
    chk("rst_state_idle", state_o, ST_IDLE);
    reset_i = 0;
    done_seen = 0;
    step();
    chk("restart_cpu", state_o, ST_CPU);
    repeat (2 * F) step();
    chk("rst_no_done", done_seen, 0);

    // Random traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      cpu_addr_i = AW'($urandom); cpu_data_i = 8'($urandom); cpu_rw_ni = 1'($urandom);
      spi_addr_i = AW'($urandom); spi_data_i = 8'($urandom); spi_rw_ni = 1'($urandom);
      ram_data_i = 8'($urandom);
      if ($urandom_range(0, 19) == 0) spi_valid_i = ~spi_valid_i;
      reset_i = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
